// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Holds the FSM state encoding, oversample constants and the bit voter.
package uart_pkg;

  localparam int OS_RATE = 16;
  localparam int OS_MID  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Oversample tick generator: one-clock tick every div+1 clocks.
// A synchronous clear restarts the count so the first tick is a full period away.
module uart_rx_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clr && (cnt == div);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver with majority vote and valid/ready output.
// Define UART_RX_PARITY_EN to expect one parity bit before the stop bits.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int DIV_W        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic [DIV_W-1:0]        clk_div,
  input  logic                    rx_ready,
  output logic                    rx_valid,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_frame_err,
  output logic                    rx_parity_err,
  output logic                    rx_break,
  output logic                    rx_overrun,
  output logic                    rx_busy
);

  localparam logic [3:0] OS_S7     = 4'(OS_MID - 1);
  localparam logic [3:0] OS_S8     = 4'(OS_MID);
  localparam logic [3:0] OS_DEC    = 4'(OS_MID + 1);
  localparam logic [3:0] OS_END    = 4'(OS_RATE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(PAYLOAD_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_t state, state_nx;

  logic                    rxd_m, rxd_s;
  logic [DIV_W-1:0]        div_q;
  logic                    tick, clr;
  logic [3:0]              os;
  logic                    s7, s8;
  logic [3:0]              bit_cnt;
  logic                    stop_cnt;
  logic [PAYLOAD_BITS-1:0] shift;
  logic                    stop_any0, stop_all0;
  logic                    par_err;
  logic                    done_q, fe_q, pe_q, brk_q;

  logic bit_v, decide, edge_b;
  logic any0_now, all0_now;
  logic frame_done, is_break;

  assign bit_v      = maj3(s7, s8, rxd_s);
  assign decide     = tick && (os == OS_DEC);
  assign edge_b     = tick && (os == OS_END);
  assign any0_now   = stop_any0 | ~bit_v;
  assign all0_now   = stop_all0 & ~bit_v;
  assign frame_done = (state == S_STOP) && decide
                   && (stop_cnt == LAST_STOP);
  assign rx_busy    = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  assign is_break = frame_done && (shift == '0)
                 && all0_now && !par_bit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else if (state == S_PARITY && decide) begin
      par_bit <= bit_v;
      par_err <= (^shift) ^ bit_v ^ 1'(PARITY_ODD);
    end
  end
`else
  assign is_break = frame_done && (shift == '0) && all0_now;
  assign par_err  = 1'b0;
`endif

  uart_rx_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk   (clk),
    .resetn(resetn),
    .clr   (clr),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (uart_rx_en && !rxd_s) begin
          state_nx = S_START;
          clr      = 1'b1;
        end
      end
      S_START: begin
        if (decide && bit_v) state_nx = S_IDLE;
        else if (edge_b)     state_nx = S_DATA;
      end
      S_DATA: begin
        if (edge_b && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (edge_b) state_nx = S_STOP;
      end
      S_STOP: begin
        if (frame_done)
          state_nx = is_break ? S_BRK_WAIT : S_IDLE;
      end
      S_BRK_WAIT: begin
        if (rxd_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // disabling the receiver abandons any frame in flight
    if (state != S_IDLE && !uart_rx_en) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      state     <= S_IDLE;
      div_q     <= '0;
      os        <= '0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      stop_any0 <= 1'b0;
      stop_all0 <= 1'b1;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rxd_m  <= uart_rxd;
      rxd_s  <= rxd_m;
      state  <= state_nx;
      done_q <= frame_done && uart_rx_en;
      fe_q   <= any0_now;
      pe_q   <= par_err;
      brk_q  <= is_break;
      if (clr) begin
        div_q     <= clk_div;
        os        <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        stop_any0 <= 1'b0;
        stop_all0 <= 1'b1;
      end else begin
        if (tick) os <= os + 4'd1;
        if (tick && os == OS_S7) s7 <= rxd_s;
        if (tick && os == OS_S8) s8 <= rxd_s;
        if (state == S_DATA && decide)
          shift <= {bit_v, shift[PAYLOAD_BITS-1:1]};
        if (state == S_DATA && edge_b)
          bit_cnt <= bit_cnt + 4'd1;
        if (state == S_STOP && edge_b)
          stop_cnt <= 1'b1;
        if (state == S_STOP && decide) begin
          stop_any0 <= any0_now;
          stop_all0 <= all0_now;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= shift;
          rx_frame_err  <= fe_q;
          rx_parity_err <= pe_q;
          rx_break      <= brk_q;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
